bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 32 +++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 184 ++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_e    - controller states (IDLE / SHIFT / DONE), fixed 2-bit encoding
//   min_digits - constant function: decimal digits needed to show 2^bin_w-1
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of decimal digits in the largest unsigned value of bin_w bits.
  // Used at elaboration to reject a DIGITS setting that cannot hold the result.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    int              n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n       = 0;
    while (max_val != 64'd0) begin
      max_val = max_val / 64'd10;
      n++;
    end
    if (n == 0) begin
      n = 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more, so
// that the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_in  [3:0] - BCD digit before correction
//   digit_out [3:0] - corrected digit (digit_in + 3 when digit_in >= 5)
// -----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one operand bit per clock. Valid/ready handshakes on both sides; a new
// operand is only accepted once the previous result has been taken.
//
// Parameters:
//   BIN_W  - binary input width (4..32)
//   DIGITS - number of BCD output digits (must cover 2^BIN_W-1)
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset, aborts any conversion
//   in_valid  - bin_in holds a value to convert
//   in_ready  - converter is idle and will accept bin_in
//   bin_in    - binary operand
//   out_valid - bcd_out/sign_out hold a finished result (registered)
//   out_ready - consumer takes the result
//   bcd_out   - packed BCD, digit 0 (ones) in bits [3:0] (registered)
//   sign_out  - result negative; constant 0 in the unsigned build
//
// Build option:
//   BIN2BCD_SIGNED_EN - when defined, bin_in is two's complement; the
//   magnitude is converted and sign_out reports the operand's MSB.
//
// Timing: the accepting edge loads the operand, then BIN_W SHIFT edges follow;
// out_valid rises on the last of those, i.e. on the (BIN_W+1)-th edge counting
// the accepting one.
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
      $error("bin2bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  state_e           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [BIN_W-1:0] op_reg, op_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [ACC_W-1:0] bcd_out_reg, bcd_out_next;

  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_shift;
  logic [BIN_W-1:0] op_shift;
  logic [BIN_W-1:0] load_mag;
  logic             accept;

  assign accept = (state_reg == IDLE) && in_valid;

  // ---------------------------------------------------------------------------
  // Operand conditioning and sign tracking
  // ---------------------------------------------------------------------------
`ifdef BIN2BCD_SIGNED_EN
  logic sign_reg;

  // The negated most-negative value wraps to itself, which read as unsigned
  // is exactly its magnitude (e.g. 8'h80 -> 128), so BIN_W bits suffice.
  assign load_mag = bin_in[BIN_W-1] ? ((~bin_in) + {{(BIN_W-1){1'b0}}, 1'b1})
                                    : bin_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg <= 1'b0;
    end else if (accept) begin
      sign_reg <= bin_in[BIN_W-1];
    end
  end

  assign sign_out = sign_reg;
`else
  assign load_mag = bin_in;
  assign sign_out = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction, then one left shift of {accumulator, operand}
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit_in  (acc_reg[4*gi +: 4]),
        .digit_out (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  // With enough digits the bit shifted out of the top is always zero.
  assign {acc_shift, op_shift} = {acc_adj, op_reg} << 1;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    bcd_out_next   = bcd_out_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next    = load_mag;
          acc_next   = '0;
          cnt_next   = CNT_W'(BIN_W);
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        acc_next = acc_shift;
        op_next  = op_shift;
        cnt_next = cnt_reg - CNT_W'(1);
        // Last bit: publish the shifted accumulator on the same edge so the
        // output register and out_valid change together.
        if (cnt_reg == CNT_W'(1)) begin
          state_next     = DONE;
          out_valid_next = 1'b1;
          bcd_out_next   = acc_shift;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      end

      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      op_reg        <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      bcd_out_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      op_reg        <= op_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      bcd_out_reg   <= bcd_out_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign bcd_out   = bcd_out_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq (BIN_W=8, DIGITS=3). Directed vector
// table, hand-written handshake/reset sequences, and random operands checked
// against an arithmetic decimal model. Honours BIN2BCD_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int LAT    = BIN_W + 1;   // edges from accept (inclusive) to out_valid

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [BIN_W-1:0]    bin_in = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [4*DIGITS-1:0] bcd_out;
  logic                sign_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .sign_out  (sign_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [BIN_W-1:0]    bin;
    logic [4*DIGITS-1:0] bcd;
    logic                sign;
  } vec_t;

  vec_t vecs[8];

  // Reference model: decimal digits by plain arithmetic on the magnitude.
  function automatic logic [11:0] ref_bcd(input int unsigned v);
    int unsigned mag;
    mag = v;
`ifdef BIN2BCD_SIGNED_EN
    if (v >= 128) mag = 256 - v;
`endif
    return {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  function automatic logic ref_sign(input int unsigned v);
`ifdef BIN2BCD_SIGNED_EN
    return v >= 128;
`else
    return (v > 1000);   // never true for an 8-bit operand
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called #1 after a rising edge; presents v for exactly one edge.
  task automatic do_accept(input logic [BIN_W-1:0] v);
    check("accept_in_ready", {31'd0, in_ready}, 32'd1);
    bin_in   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges (including the accepting one) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) check("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("take_out_valid", {31'd0, out_valid}, 32'd0);
    check("take_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic convert_check(input string tag, input logic [BIN_W-1:0] v,
                               input logic [11:0] exp_bcd, input logic exp_sign);
    int lat;
    do_accept(v);
    wait_valid(lat);
    $display("%s: bin_in=%0d lat=%0d bcd_out=%03h sign_out=%0b (exp %03h/%0b)",
             tag, v, lat, bcd_out, sign_out, exp_bcd, exp_sign);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp_bcd});
    check({tag, "_sign"}, {31'd0, sign_out}, {31'd0, exp_sign});
  endtask

  initial begin
    int lat;
    int stall;
    logic [11:0] held;
    logic [BIN_W-1:0] rv;

`ifdef BIN2BCD_SIGNED_EN
    vecs[0] = '{8'd0,   12'h000, 1'b0};
    vecs[1] = '{8'd99,  12'h099, 1'b0};
    vecs[2] = '{8'd100, 12'h100, 1'b0};
    vecs[3] = '{8'd127, 12'h127, 1'b0};
    vecs[4] = '{8'h80,  12'h128, 1'b1};
    vecs[5] = '{8'hFF,  12'h001, 1'b1};
    vecs[6] = '{8'h9C,  12'h100, 1'b1};
    vecs[7] = '{8'd9,   12'h009, 1'b0};
`else
    vecs[0] = '{8'd0,   12'h000, 1'b0};
    vecs[1] = '{8'd99,  12'h099, 1'b0};
    vecs[2] = '{8'd100, 12'h100, 1'b0};
    vecs[3] = '{8'd255, 12'h255, 1'b0};
    vecs[4] = '{8'd1,   12'h001, 1'b0};
    vecs[5] = '{8'd9,   12'h009, 1'b0};
    vecs[6] = '{8'd10,  12'h010, 1'b0};
    vecs[7] = '{8'd173, 12'h173, 1'b0};
`endif

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    #1;
    $display("reset: in_ready=%0b out_valid=%0b bcd_out=%03h sign_out=%0b",
             in_ready, out_valid, bcd_out, sign_out);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd", {20'd0, bcd_out}, 32'd0);
    check("rst_sign", {31'd0, sign_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      convert_check("vec", vecs[i].bin, vecs[i].bcd, vecs[i].sign);
      take();
    end

    // out_ready high while idle and shifting is ignored; result still
    // appears after the full latency and is taken on the next edge.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_ignored", {31'd0, out_valid}, 32'd0);
    do_accept(8'd255);
    wait_valid(lat);
    $display("ready_held: bin_in=255 lat=%0d bcd_out=%03h", lat, bcd_out);
    check("ready_held_latency", lat, LAT);
    check("ready_held_bcd", {20'd0, bcd_out}, {20'd0, ref_bcd(255)});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ready_held_consumed", {31'd0, out_valid}, 32'd0);

    // Backpressure: result held 20 cycles, new in_valid ignored.
    convert_check("bp", 8'd173, ref_bcd(173), ref_sign(173));
    held     = bcd_out;
    bin_in   = 8'd5;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_bcd_held", {20'd0, bcd_out}, {20'd0, ref_bcd(173)});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    $display("bp: held 20 cycles bcd_out=%03h (was %03h)", bcd_out, held);
    in_valid = 1'b0;
    take();
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_stray_result", {31'd0, out_valid}, 32'd0);

    // Reset 4 cycles into a conversion, with a previous result in bcd_out.
    do_accept(8'd200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("rst_mid: in_ready=%0b out_valid=%0b bcd_out=%03h", in_ready, out_valid, bcd_out);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_bcd", {20'd0, bcd_out}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("rst_mid_discarded", {31'd0, out_valid}, 32'd0);
    convert_check("after_rst", 8'd42, 12'h042, 1'b0);
    take();

    // Reset while a result waits in DONE.
    convert_check("done_rst", 8'd77, ref_bcd(77), ref_sign(77));
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    $display("rst_done: out_valid=%0b bcd_out=%03h", out_valid, bcd_out);
    check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done_bcd", {20'd0, bcd_out}, 32'd0);
    check("rst_done_in_ready", {31'd0, in_ready}, 32'd1);

    // Random operands with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      rv = BIN_W'($urandom_range(0, 255));
      convert_check("rand", rv, ref_bcd(rv), ref_sign(rv));
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        #1;
        check("rand_hold_bcd", {20'd0, bcd_out}, {20'd0, ref_bcd(rv)});
        check("rand_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      take();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
